// File: rtl/ceas_pkg.sv
// Shared types and helpers for the clock time-load path.
// Field widths, source codes and arbiter state encoding.
package ceas_pkg;

    localparam int ORE_W = 5;
    localparam int MIN_W = 6;

    localparam logic SRC_MANUAL = 1'b0;
    localparam logic SRC_UART   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_HOLDOFF
    } state_t;

    typedef struct packed {
        logic [ORE_W-1:0] ore;
        logic [MIN_W-1:0] minute;
    } snap_t;

    // Raw widths are compared as-is: 31 h or 63 min stay invalid.
    function automatic logic time_valid(
        input snap_t s,
        input int    max_ore,
        input int    max_min
    );
        return (int'(s.ore) <= max_ore) &&
               (int'(s.minute) <= max_min);
    endfunction

endpackage

// File: rtl/holdoff_timer.sv
// Loadable down-counter that spaces consecutive time-load grants.
// done flags the cycle in which the count reaches zero.
module holdoff_timer #(
    parameter int CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic count,
    output logic done
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= W'(CYCLES);
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = count && (cnt == W'(1));

endmodule

// File: rtl/time_load_arbiter.sv
// Arbitrates manual and UART time-load requests into the counter.
// One load pulse per grant, followed by a fixed hold-off gap.
module time_load_arbiter
    import ceas_pkg::*;
#(
    parameter int   HOLDOFF_CYCLES = 4,
    parameter int   MAX_ORE        = 23,
    parameter int   MAX_MIN        = 59,
    parameter logic PRIO_MANUAL    = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_manual,
    input  logic [ORE_W-1:0] ore_manual,
    input  logic [MIN_W-1:0] minute_manual,
    input  logic             req_uart,
    input  logic [ORE_W-1:0] ore_uart,
    input  logic [MIN_W-1:0] minute_uart,
    input  logic             lock,
    output logic             load_out,
    output logic [ORE_W-1:0] ore_out,
    output logic [MIN_W-1:0] minute_out,
    output logic             busy,
    output logic             err_invalid,
    output logic             last_src
);

    state_t state;
    logic   pend_m;
    logic   pend_u;
    snap_t  snap_m;
    snap_t  snap_u;
    snap_t  sel;
    logic   elig_m;
    logic   elig_u;
    logic   pick_uart;
    logic   take;
    logic   sel_ok;
    logic   tmr_done;

    always_comb begin
        elig_m    = pend_m;
        elig_u    = pend_u & ~lock;
        pick_uart = elig_u & (~elig_m | ~PRIO_MANUAL);
        sel       = pick_uart ? snap_u : snap_m;
        take      = (state == ST_IDLE) & (elig_m | elig_u);
        sel_ok    = time_valid(sel, MAX_ORE, MAX_MIN);
    end

    // A request on the serving edge wins over clearing the slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_m <= 1'b0;
            pend_u <= 1'b0;
            snap_m <= '0;
            snap_u <= '0;
        end else begin
            if (req_manual) begin
                pend_m <= 1'b1;
                snap_m <= '{ore: ore_manual,
                            minute: minute_manual};
            end else if (take && !pick_uart) begin
                pend_m <= 1'b0;
            end
            if (req_uart) begin
                pend_u <= 1'b1;
                snap_u <= '{ore: ore_uart,
                            minute: minute_uart};
            end else if (take && pick_uart) begin
                pend_u <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            load_out    <= 1'b0;
            err_invalid <= 1'b0;
            ore_out     <= '0;
            minute_out  <= '0;
            last_src    <= SRC_MANUAL;
        end else begin
            load_out    <= 1'b0;
            err_invalid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (take) begin
                        last_src <= pick_uart ? SRC_UART
                                              : SRC_MANUAL;
                        if (sel_ok) begin
                            ore_out    <= sel.ore;
                            minute_out <= sel.minute;
                            load_out   <= 1'b1;
                            state      <= ST_GRANT;
                        end else begin
                            err_invalid <= 1'b1;
                        end
                    end
                end
                ST_GRANT: begin
                    state <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (tmr_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    holdoff_timer #(
        .CYCLES(HOLDOFF_CYCLES)
    ) u_holdoff (
        .clock(clock),
        .reset(reset),
        .start(state == ST_GRANT),
        .count(state == ST_HOLDOFF),
        .done (tmr_done)
    );

    assign busy = (state != ST_IDLE) | pend_m | pend_u;

endmodule

// File: tb/tb_time_load_arbiter.sv
// Randomized scoreboard bench for time_load_arbiter.
// Reference model tracks pending slots and the next allowed grant cycle.
module tb_time_load_arbiter;

    localparam int H       = 4;
    localparam int MAX_O   = 23;
    localparam int MAX_M   = 59;
    localparam bit PRIO_M  = 1'b1;

    logic       clock;
    logic       reset;
    logic       req_manual;
    logic [4:0] ore_manual;
    logic [5:0] minute_manual;
    logic       req_uart;
    logic [4:0] ore_uart;
    logic [5:0] minute_uart;
    logic       lock;
    logic       load_out;
    logic [4:0] ore_out;
    logic [5:0] minute_out;
    logic       busy;
    logic       err_invalid;
    logic       last_src;

    time_load_arbiter #(
        .HOLDOFF_CYCLES(H),
        .MAX_ORE(MAX_O),
        .MAX_MIN(MAX_M),
        .PRIO_MANUAL(PRIO_M)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_manual(req_manual),
        .ore_manual(ore_manual),
        .minute_manual(minute_manual),
        .req_uart(req_uart),
        .ore_uart(ore_uart),
        .minute_uart(minute_uart),
        .lock(lock),
        .load_out(load_out),
        .ore_out(ore_out),
        .minute_out(minute_out),
        .busy(busy),
        .err_invalid(err_invalid),
        .last_src(last_src)
    );

    typedef struct {
        bit err;
        int ore;
        int mn;
        bit src;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // model state
    bit pm, pu;
    int mo, mm, uo, um;
    int ready_at = 0;
    int exp_ore = 0;
    int exp_min = 0;
    bit exp_src = 0;
    bit exp_busy = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int got,
                       input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d cycle %0d",
                     name, got, want, cyc);
        end
    endtask

    // Reference model: grant allowed at edge c when c >= ready_at.
    initial begin
        ev_t e;
        bit em, eu, src, ok;
        int o, m;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                pm = 0; pu = 0;
                ready_at = 0;
                exp_q.delete();
                exp_ore = 0; exp_min = 0;
                exp_src = 0; exp_busy = 0;
            end else begin
                cyc++;
                em = pm;
                eu = pu && !lock;
                if (cyc >= ready_at && (em || eu)) begin
                    src = !(em && (PRIO_M || !eu));
                    o = src ? uo : mo;
                    m = src ? um : mm;
                    ok = (o <= MAX_O) && (m <= MAX_M);
                    e.err = !ok;
                    e.ore = o;
                    e.mn = m;
                    e.src = src;
                    e.cyc = cyc;
                    exp_q.push_back(e);
                    exp_src = src;
                    if (ok) begin
                        exp_ore = o;
                        exp_min = m;
                        ready_at = cyc + H + 2;
                    end
                    if (src) pu = 0;
                    else pm = 0;
                end
                if (req_manual) begin
                    pm = 1;
                    mo = int'(ore_manual);
                    mm = int'(minute_manual);
                end
                if (req_uart) begin
                    pu = 1;
                    uo = int'(ore_uart);
                    um = int'(minute_uart);
                end
                exp_busy = (cyc < ready_at - 1) || pm || pu;
            end
        end
    end

    // Monitor: pops an expected event whenever a strobe appears.
    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    chk("missing_event", 0, 1);
                end
                if (load_out || err_invalid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("load_out", int'(load_out),
                            int'(!e.err));
                        chk("err_invalid", int'(err_invalid),
                            int'(e.err));
                        chk("event_src", int'(last_src),
                            int'(e.src));
                        if (!e.err) begin
                            chk("grant_ore", int'(ore_out), e.ore);
                            chk("grant_min", int'(minute_out), e.mn);
                        end
                    end
                end
                chk("ore_out", int'(ore_out), exp_ore);
                chk("minute_out", int'(minute_out), exp_min);
                chk("last_src", int'(last_src), int'(exp_src));
                chk("busy", int'(busy), int'(exp_busy));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        req_manual = 0;
        req_uart = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic man(input int o, input int m);
        req_manual = 1;
        ore_manual = 5'(o);
        minute_manual = 6'(m);
    endtask

    task automatic uart(input int o, input int m);
        req_uart = 1;
        ore_uart = 5'(o);
        minute_uart = 6'(m);
    endtask

    task automatic reset_pulse();
        reset = 0;
        #1;
        chk("rst_load", int'(load_out), 0);
        chk("rst_ore", int'(ore_out), 0);
        chk("rst_min", int'(minute_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_invalid), 0);
        chk("rst_src", int'(last_src), 0);
        step();
        step();
        reset = 1;
    endtask

    function automatic int rnd_ore();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 31);
        return $urandom_range(0, 23);
    endfunction

    function automatic int rnd_min();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 63);
        return $urandom_range(0, 59);
    endfunction

    initial begin
        reset = 0;
        req_manual = 0; ore_manual = 0; minute_manual = 0;
        req_uart = 0; ore_uart = 0; minute_uart = 0;
        lock = 0;
        #1;
        chk("init_load", int'(load_out), 0);
        chk("init_busy", int'(busy), 0);
        idle(2);
        reset = 1;
        idle(2);

        man(13, 45); step(); idle(8);

        man(8, 0); uart(9, 30); step(); idle(12);

        lock = 1; uart(22, 10); step(); idle(6);
        lock = 0; idle(10);

        uart(24, 0); step(); idle(2);
        man(10, 60); step(); idle(3);
        man(31, 0); uart(0, 63); step(); idle(4);
        man(23, 59); step(); idle(8);

        lock = 1; uart(5, 5); step();
        uart(6, 6); step();
        lock = 0; idle(10);
        man(1, 2); step();
        man(3, 4); step(); idle(12);

        man(12, 0); step(); idle(3);
        uart(14, 0); step();
        reset_pulse();
        idle(12);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0) man(rnd_ore(), rnd_min());
            if ($urandom_range(0, 5) == 0) uart(rnd_ore(), rnd_min());
            if ($urandom_range(0, 19) == 0) lock = ~lock;
            if ($urandom_range(0, 399) == 0) reset_pulse();
            else step();
        end

        lock = 0;
        idle(30);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
